// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy width and stage-buffer state encoding.
// Optional skid buffer in pipe_stage_buf is enabled by PIPE_STAGE_SKID_EN.
package pipe_pkg;

   localparam int OCC_W = 2;

   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_ONE   = 2'd1,
      PIPE_TWO   = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Shared by the stage buffers and other performance counters.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   // count events, stick at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with flush, stall counter and an
// optional 2-entry skid buffer selected by PIPE_STAGE_SKID_EN.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              stat_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   pipe_state_t       state;
   logic [DATA_W-1:0] main_q;
`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] skid_q;
`endif
   logic              vld_q;
   logic [OCC_W-1:0]  occ_q;
   logic              in_fire;
   logic              out_fire;

`ifdef PIPE_STAGE_SKID_EN
   // only a full stage refuses; decoded from state flops alone
   assign in_ready = (state != PIPE_TWO);
`else
   // single entry: accept when empty or when the head leaves this cycle
   assign in_ready = ~vld_q | out_ready;
`endif

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = vld_q & out_ready;
   assign out_valid = vld_q;
   assign occupancy = occ_q;
   assign out_data  = vld_q ? main_q : '0;

   // occupancy FSM; flush drops everything, including a same-cycle push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= PIPE_EMPTY;
         main_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_q <= '0;
`endif
         vld_q  <= 1'b0;
         occ_q  <= 2'd0;
      end else if (flush) begin
         state  <= PIPE_EMPTY;
         main_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_q <= '0;
`endif
         vld_q  <= 1'b0;
         occ_q  <= 2'd0;
      end else begin
         unique case (state)
            PIPE_EMPTY: begin
               if (in_fire) begin
                  state  <= PIPE_ONE;
                  main_q <= in_data;
                  vld_q  <= 1'b1;
                  occ_q  <= 2'd1;
               end
            end
            PIPE_ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= in_data;
`ifdef PIPE_STAGE_SKID_EN
               end else if (in_fire) begin
                  state  <= PIPE_TWO;
                  skid_q <= in_data;
                  occ_q  <= 2'd2;
`endif
               end else if (out_fire) begin
                  state  <= PIPE_EMPTY;
                  main_q <= '0;
                  vld_q  <= 1'b0;
                  occ_q  <= 2'd0;
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            PIPE_TWO: begin
               if (out_fire) begin
                  state  <= PIPE_ONE;
                  main_q <= skid_q;
                  skid_q <= '0;
                  occ_q  <= 2'd1;
               end
            end
`endif
            default: begin
               state  <= PIPE_EMPTY;
               main_q <= '0;
               vld_q  <= 1'b0;
               occ_q  <= 2'd0;
            end
         endcase
      end
   end

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (vld_q & ~out_ready),
      .clr   (stat_clr),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf; a second instance with CNT_W=2
// covers stall counter saturation. Honours PIPE_STAGE_SKID_EN.
module tb_pipe_stage_buf;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        stat_clr;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   logic        in_ready2;
   logic        out_valid2;
   logic [31:0] out_data2;
   logic [1:0]  occupancy2;
   logic [1:0]  stall_cnt2;

   integer checks;
   integer errors;

   pipe_stage_buf #(.DATA_W(32), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .stat_clr  (stat_clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   pipe_stage_buf #(.DATA_W(32), .CNT_W(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .stat_clr  (stat_clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .in_data   (in_data),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .out_data  (out_data2),
      .occupancy (occupancy2),
      .stall_cnt (stall_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      stat_clr = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      #3;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL reset_out got v=%b d=%h o=%0d req 0 0 0",
                  out_valid, out_data, occupancy);
      end
      checks++;
      if (stall_cnt !== 16'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_cnt_rdy got c=%0d r=%b req 0 1", stall_cnt, in_ready);
      end
      #14;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_data = i;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== i || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL stream_%0d got v=%b d=%h o=%0d req 1 %h 1",
                     i, out_valid, out_data, occupancy, i);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stream_end got v=%b o=%0d c=%0d req 0 0 0",
                  out_valid, occupancy, stall_cnt);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'hA;
      tick();
      in_data = 32'hB;
      #1;
`ifdef PIPE_STAGE_SKID_EN
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL skid_rdy_one got %b req 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
         errors++;
         $display("FAIL skid_full got o=%0d r=%b d=%h req 2 0 a",
                  occupancy, in_ready, out_data);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_data !== 32'hB || in_ready !== 1'b1 || occupancy !== 2'd1) begin
         errors++;
         $display("FAIL skid_drain1 got d=%h r=%b o=%0d req b 1 1",
                  out_data, in_ready, occupancy);
      end
`else
      checks++;
      if (in_ready !== 1'b0 || occupancy !== 2'd1 || out_data !== 32'hA) begin
         errors++;
         $display("FAIL bp_stall got r=%b o=%0d d=%h req 0 1 a",
                  in_ready, occupancy, out_data);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_comb_rdy got %b req 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_data !== 32'hB || occupancy !== 2'd1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_next got d=%h o=%0d v=%b req b 1 1",
                  out_data, occupancy, out_valid);
      end
`endif
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL bp_empty got v=%b d=%h o=%0d req 0 0 0",
                  out_valid, out_data, occupancy);
      end
   endtask

   task automatic test_flush();
`ifdef PIPE_STAGE_SKID_EN
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h5;
      tick();
      in_data = 32'h6;
      tick();
      flush = 1'b1;
      in_data = 32'hC;
      #1;
      checks++;
      if (out_valid !== 1'b1 || occupancy !== 2'd2) begin
         errors++;
         $display("FAIL flush2_same got v=%b o=%0d req 1 2", out_valid, occupancy);
      end
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL flush2_after got v=%b d=%h o=%0d req 0 0 0",
                  out_valid, out_data, occupancy);
      end
`endif
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h5;
      tick();
      flush = 1'b1;
      in_data = 32'hC;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_fire got r=%b v=%b req 1 1", in_ready, out_valid);
      end
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL flush_after got v=%b d=%h o=%0d req 0 0 0",
                  out_valid, out_data, occupancy);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0) begin
         errors++;
         $display("FAIL flush_drop got v=%b d=%h req 0 0", out_valid, out_data);
      end
   endtask

   task automatic test_stall();
      in_valid = 1'b0;
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      checks++;
      if (stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stall_clr0 got %0d req 0", stall_cnt);
      end
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h9;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      checks++;
      if (stall_cnt !== 16'd5) begin
         errors++;
         $display("FAIL stall_5 got %0d req 5", stall_cnt);
      end
      repeat (5) tick();
      checks++;
      if (stall_cnt !== 16'd10 || stall_cnt2 !== 2'd3) begin
         errors++;
         $display("FAIL stall_sat got %0d/%0d req 10/3", stall_cnt, stall_cnt2);
      end
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      checks++;
      if (stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin
         errors++;
         $display("FAIL stall_clr_win got %0d/%0d req 0/0", stall_cnt, stall_cnt2);
      end
      tick();
      checks++;
      if (stall_cnt !== 16'd1) begin
         errors++;
         $display("FAIL stall_resume got %0d req 1", stall_cnt);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      checks++;
      if (stall_cnt !== 16'd2 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_flush got c=%0d v=%b req 2 0", stall_cnt, out_valid);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h1;
      tick();
      in_data = 32'h2;
      tick();
      in_valid = 1'b0;
      checks++;
`ifdef PIPE_STAGE_SKID_EN
      if (occupancy !== 2'd2) begin
         errors++;
         $display("FAIL arst_pre got o=%0d req 2", occupancy);
      end
`else
      if (occupancy !== 2'd1) begin
         errors++;
         $display("FAIL arst_pre got o=%0d req 1", occupancy);
      end
`endif
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0 ||
          stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL arst_now got v=%b d=%h o=%0d c=%0d req 0 0 0 0",
                  out_valid, out_data, occupancy, stall_cnt);
      end
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data = 32'h77;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h77) begin
         errors++;
         $display("FAIL arst_after got v=%b d=%h req 1 77", out_valid, out_data);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL arst_drain got v=%b o=%0d req 0 0", out_valid, occupancy);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_stall();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
